// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC sin/cos path: Q-format angles and gain, default
// widths/latency, the arctangent table, and the side-band record carried beside the core.
package cordic_pkg;

   localparam int W_DEF        = 16;
   localparam int CORE_LAT_DEF = 17;
   localparam int N_ITER       = 16;

   // Angles are Q3.13 radians; amplitudes are Q2.13.
   localparam logic [15:0] PI_Q13      = 16'h6488;
   localparam logic [15:0] HALF_PI_Q13 = 16'h3244;
   localparam logic [15:0] K_GAIN_Q13  = 16'h136F;

   // atan(2^-i) in Q3.13, i = 0 .. N_ITER-1
   localparam logic [15:0] ATAN_Q13 [N_ITER] = '{
      16'h1922, 16'h0ED6, 16'h07D7, 16'h03FB,
      16'h01FF, 16'h0100, 16'h0080, 16'h0040,
      16'h0020, 16'h0010, 16'h0008, 16'h0004,
      16'h0002, 16'h0001, 16'h0000, 16'h0000
   };

   typedef struct packed {
      logic valid;
      logic fold;
      logic err;
   } side_t;

endpackage

// File: rtl/cordic_angle_prep_if.sv
// Request/result bundle of cordic_angle_prep: angle request handshake plus the
// sign-corrected cos/sin result and status.
interface cordic_angle_prep_if
   import cordic_pkg::*;
#(
   parameter int W = W_DEF
);
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] in_angle;
   logic                out_valid;
   logic signed [W-1:0] out_cos;
   logic signed [W-1:0] out_sin;
   logic                out_range_err;
   logic                busy;

   modport slave (
      input  in_valid, in_angle,
      output in_ready, out_valid, out_cos, out_sin, out_range_err, busy
   );

   modport master (
      output in_valid, in_angle,
      input  in_ready, out_valid, out_cos, out_sin, out_range_err, busy
   );
endinterface

// File: rtl/cordic_delay_line.sv
// Fixed-depth shift register with asynchronous clear; also exposes one chosen bit
// of every stage so the owner can see what is still in flight.
module cordic_delay_line #(
   parameter int DEPTH    = 17,
   parameter int WIDTH    = 3,
   parameter int FLAG_BIT = WIDTH - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [DEPTH-1:0] flag_taps
);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH-1:0] q_reg;

         if (gi == 0) begin : g_head
            always_ff @(posedge clk or posedge rst) begin
               if (rst) q_reg <= '0;
               else     q_reg <= din;
            end
         end else begin : g_body
            always_ff @(posedge clk or posedge rst) begin
               if (rst) q_reg <= '0;
               else     q_reg <= g_stage[gi-1].q_reg;
            end
         end

         assign flag_taps[gi] = q_reg[FLAG_BIT];
      end
   endgenerate

   assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/cordic_angle_prep.sv
// Front/back end for the pipelined CORDIC rotation core: folds a full-circle angle
// into [-pi/2, +pi/2], feeds the core, and sign-corrects its X/Y into cos/sin.
module cordic_angle_prep
   import cordic_pkg::*;
#(
   parameter int           W        = W_DEF,
   parameter int           CORE_LAT = CORE_LAT_DEF,
   parameter logic [W-1:0] K_INIT   = W'(K_GAIN_Q13)
) (
   input  logic                 clk,
   input  logic                 rst,
   cordic_angle_prep_if.slave   req,
   output logic signed [W-1:0]  core_xin,
   output logic signed [W-1:0]  core_yin,
   output logic signed [W-1:0]  core_zin,
   input  logic signed [W-1:0]  core_x0,
   input  logic signed [W-1:0]  core_y0
);

   localparam logic signed [W-1:0] PI_W          = W'($signed(PI_Q13));
   localparam logic signed [W-1:0] NEG_PI_W      = -PI_W;
   localparam logic signed [W-1:0] HALF_PI_W     = W'($signed(HALF_PI_Q13));
   localparam logic signed [W-1:0] NEG_HALF_PI_W = -HALF_PI_W;
   localparam logic signed [W-1:0] SAT_MAX       = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN       = {1'b1, {(W-1){1'b0}}};

   // First stage shadows the prep register, the remaining CORE_LAT stages track the core.
   localparam int DL_DEPTH = CORE_LAT + 1;

   logic                in_ready_reg;
   logic                transfer;
   logic signed [W-1:0] angle;
   logic signed [W-1:0] clamped;
   logic signed [W-1:0] z_fold;
   logic                range_err;
   logic                fold_flag;

   logic signed [W-1:0] core_xin_reg;
   logic signed [W-1:0] core_yin_reg;
   logic signed [W-1:0] core_zin_reg;

   side_t               dl_in;
   side_t               dl_tail;
   logic [DL_DEPTH-1:0] dl_valid;

   logic                out_valid_reg;
   logic                out_err_reg;
   logic signed [W-1:0] out_cos_reg;
   logic signed [W-1:0] out_sin_reg;

   function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
      return (v == SAT_MIN) ? SAT_MAX : -v;
   endfunction

   assign angle    = req.in_angle;
   assign transfer = req.in_valid && in_ready_reg;

   // The core never stalls, so ready only reflects having come out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) in_ready_reg <= 1'b0;
      else     in_ready_reg <= 1'b1;
   end

   // Wrap-free W-bit arithmetic: a folded result always lands inside +/-HALF_PI.
   always_comb begin
      clamped   = angle;
      range_err = 1'b0;
      z_fold    = angle;
      fold_flag = 1'b0;
      if (angle > PI_W) begin
         clamped   = PI_W;
         range_err = 1'b1;
      end else if (angle < NEG_PI_W) begin
         clamped   = NEG_PI_W;
         range_err = 1'b1;
      end
      z_fold = clamped;
      if (clamped > HALF_PI_W) begin
         z_fold    = clamped - PI_W;
         fold_flag = 1'b1;
      end else if (clamped < NEG_HALF_PI_W) begin
         z_fold    = clamped + PI_W;
         fold_flag = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_xin_reg <= K_INIT;
         core_yin_reg <= '0;
         core_zin_reg <= '0;
      end else if (transfer) begin
         core_xin_reg <= K_INIT;
         core_yin_reg <= '0;
         core_zin_reg <= z_fold;
      end
   end

   assign core_xin = core_xin_reg;
   assign core_yin = core_yin_reg;
   assign core_zin = core_zin_reg;

   always_comb begin
      dl_in = '0;
      if (transfer) begin
         dl_in.valid = 1'b1;
         dl_in.fold  = fold_flag;
         dl_in.err   = range_err;
      end
   end

   cordic_delay_line #(
      .DEPTH    (DL_DEPTH),
      .WIDTH    ($bits(side_t)),
      .FLAG_BIT ($bits(side_t) - 1)
   ) u_side_dl (
      .clk       (clk),
      .rst       (rst),
      .din       (dl_in),
      .dout      (dl_tail),
      .flag_taps (dl_valid)
   );

   // Results only move when the matching side-band says the core output is real.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_err_reg   <= 1'b0;
         out_cos_reg   <= '0;
         out_sin_reg   <= '0;
      end else begin
         out_valid_reg <= dl_tail.valid;
         out_err_reg   <= dl_tail.valid & dl_tail.err;
         if (dl_tail.valid) begin
            out_cos_reg <= dl_tail.fold ? neg_sat(core_x0) : core_x0;
            out_sin_reg <= dl_tail.fold ? neg_sat(core_y0) : core_y0;
         end
      end
   end

   assign req.in_ready      = in_ready_reg;
   assign req.out_valid     = out_valid_reg;
   assign req.out_cos       = out_cos_reg;
   assign req.out_sin       = out_sin_reg;
   assign req.out_range_err = out_err_reg;
   assign req.busy          = (|dl_valid) | out_valid_reg;

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Bench for cordic_angle_prep: behavioural 17-cycle CORDIC core, scoreboard of
// reference cos/sin per accepted angle, directed boundary, stream and reset cases.
module tb_cordic_angle_prep;
   import cordic_pkg::*;

   localparam int W       = W_DEF;
   localparam int CLAT    = CORE_LAT_DEF;
   localparam int LATENCY = CLAT + 2;
   localparam int PI_INT  = 25736;
   localparam int K_INT   = 4975;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic signed [W-1:0] core_xin, core_yin, core_zin, core_x0, core_y0;
   logic [2*W-1:0] core_pipe [CLAT];

   int cyc = 0;
   int n_checks = 0;
   int n_pass = 0;
   int out_count = 0;
   int run_len = 0;
   int max_run = 0;

   typedef struct {
      int cos_v;
      int sin_v;
      int err;
      int stamp;
      int angle;
   } exp_t;
   exp_t sb_q[$];

   cordic_angle_prep_if #(.W(W)) bus ();

   cordic_angle_prep #(.W(W), .CORE_LAT(CLAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (bus),
      .core_xin (core_xin),
      .core_yin (core_yin),
      .core_zin (core_zin),
      .core_x0  (core_x0),
      .core_y0  (core_y0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Rotation-mode CORDIC with 10 guard bits, 16 iterations.
   function automatic logic [2*W-1:0] cordic_model(input logic signed [W-1:0] xi,
                                                    input logic signed [W-1:0] yi,
                                                    input logic signed [W-1:0] zi);
      longint x, y, z, xs, ys, at;
      x = longint'(xi) <<< 10;
      y = longint'(yi) <<< 10;
      z = longint'(zi) <<< 10;
      for (int i = 0; i < 16; i++) begin
         at = longint'($atan(1.0 / (2.0 ** i)) * 8192.0 * 1024.0);
         xs = x >>> i;
         ys = y >>> i;
         if (z >= 0) begin
            x = x - ys; y = y + xs; z = z - at;
         end else begin
            x = x + ys; y = y - xs; z = z + at;
         end
      end
      x = (x + 512) >>> 10;
      y = (y + 512) >>> 10;
      return {x[W-1:0], y[W-1:0]};
   endfunction

   always @(posedge clk) begin
      core_pipe[0] <= cordic_model(core_xin, core_yin, core_zin);
      for (int i = 1; i < CLAT; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign {core_x0, core_y0} = core_pipe[CLAT-1];

   task automatic check(input string tag, input int got, input int exp, input int tol = 0);
      int diff;
      diff = got - exp;
      if (diff < 0) diff = -diff;
      n_checks++;
      if (diff <= tol) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                    tag, got, got, exp, exp, tol);
   endtask

   task automatic push_expect(input logic signed [W-1:0] ang);
      exp_t e;
      int   a;
      a     = int'(ang);
      e.err = 0;
      if (a > PI_INT) begin
         a = PI_INT;  e.err = 1;
      end else if (a < -PI_INT) begin
         a = -PI_INT; e.err = 1;
      end
      e.cos_v = int'(8192.0 * $cos(real'(a) / 8192.0));
      e.sin_v = int'(8192.0 * $sin(real'(a) / 8192.0));
      e.stamp = cyc;
      e.angle = int'(ang);
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic v, input logic [W-1:0] ang);
      @(negedge clk);
      bus.in_valid = v;
      bus.in_angle = ang;
      if (v && bus.in_ready && !rst) push_expect(ang);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("drain_left", sb_q.size(), 0);
   endtask

   task automatic single(input logic [W-1:0] ang, input logic [W-1:0] exp_z, input string tag);
      drive(1'b1, ang);
      drive(1'b0, '0);
      check({tag, "_zin"}, int'(core_zin), int'($signed(exp_z)));
      check({tag, "_xin"}, int'(core_xin), K_INT);
      check({tag, "_yin"}, int'(core_yin), 0);
      wait_drain();
   endtask

   // Output monitor: one line per completed transaction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            out_count++;
            if (sb_q.size() == 0) begin
               check("spurious_out_valid", int'(bus.out_valid), 0);
            end else begin
               e = sb_q.pop_front();
               check("out_cos", int'(bus.out_cos), e.cos_v, 4);
               check("out_sin", int'(bus.out_sin), e.sin_v, 4);
               check("out_range_err", int'(bus.out_range_err), e.err);
               check("latency", cyc - e.stamp, LATENCY);
               $display("txn angle=0x%04h cos=%0d (ref %0d) sin=%0d (ref %0d) err=%0d cycle=%0d",
                        e.angle[15:0], bus.out_cos, e.cos_v, bus.out_sin, e.sin_v,
                        bus.out_range_err, cyc);
            end
         end else begin
            run_len = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bus.in_valid = 1'b0;
      bus.in_angle = '0;

      repeat (3) @(negedge clk);
      check("rst_in_ready",  int'(bus.in_ready), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_busy",      int'(bus.busy), 0);
      check("rst_range_err", int'(bus.out_range_err), 0);
      check("rst_out_cos",   int'(bus.out_cos), 0);
      check("rst_out_sin",   int'(bus.out_sin), 0);
      check("rst_core_xin",  int'(core_xin), K_INT);
      check("rst_core_yin",  int'(core_yin), 0);
      check("rst_core_zin",  int'(core_zin), 0);

      rst = 1'b0;
      #1 check("ready_before_edge", int'(bus.in_ready), 0);
      @(negedge clk);
      check("ready_after_edge", int'(bus.in_ready), 1);

      single(16'h0000, 16'h0000, "zero");
      single(16'h6488, 16'h0000, "pos_pi");
      single(16'h3244, 16'h3244, "half_pi");
      single(16'h3245, 16'hCDBD, "above_half_pi");
      single(16'hCDBC, 16'hCDBC, "neg_half_pi");
      single(16'hCDBB, 16'h3243, "below_neg_half_pi");
      single(16'h7000, 16'h0000, "clamp_pos");
      single(16'h8000, 16'h0000, "clamp_neg");

      // Back-to-back stream across the whole circle.
      base    = out_count;
      max_run = 0;
      for (int k = 0; k < 20; k++) drive(1'b1, W'(int'(16'h9B78) + k * 2560));
      drive(1'b0, '0);
      check("busy_inflight", int'(bus.busy), 1);
      wait_drain();
      check("busy_last_out", int'(bus.busy), 1);
      @(negedge clk);
      check("busy_idle", int'(bus.busy), 0);
      check("stream_count", out_count - base, 20);
      check("stream_run", max_run, 20);

      // One-cycle reset in the middle of a stream drops everything in flight.
      base = out_count;
      for (int k = 0; k < 8; k++) drive(1'b1, W'(k * 1000));
      @(negedge clk);
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_angle = 16'h0100;
      sb_q.delete();
      #1;
      check("ready_in_rst", int'(bus.in_ready), 0);
      check("busy_in_rst",  int'(bus.busy), 0);
      @(negedge clk);
      rst          = 1'b0;
      bus.in_angle = 16'h0200;
      #1 check("ready_rst_fall", int'(bus.in_ready), 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("ready_edge_after_rst", int'(bus.in_ready), 1);
      repeat (25) @(negedge clk);
      check("dropped_outputs", out_count - base, 0);
      check("busy_after_drop", int'(bus.busy), 0);

      base = out_count;
      single(16'h1000, 16'h1000, "post_rst");
      check("post_rst_count", out_count - base, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
